// File: rtl/apb_ctrl_pkg.sv
// Shared types for the two-requester APB master: FSM state, default bus widths,
// requester command record and the wait-counter sizing helper.
package apb_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // A disabled timeout (0) still needs a 1-bit counter to keep the netlist legal.
  function automatic int cnt_width(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/apb_master_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the other side after every grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  // Granting requester 0 hands priority to 1 and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) ptr_d = gnt[0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two req/done requesters: round-robin grant, SETUP/ACCESS
// sequencing and a wait-state timeout that aborts a transfer stuck on pready=0.
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int               CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              gnt_idx_q, gnt_idx_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        gnt;
  logic              start, tmo_hit, finish;

  assign start   = (state_q == IDLE) && (req != 2'b00);
  assign tmo_hit = (TIMEOUT != 0) && (wait_q == TMO_CNT) && !pready;
  assign finish  = (state_q == ACCESS) && (pready || tmo_hit);

  rr_arb2 u_arb (
    .clk_i   (pclk),
    .rst_i   (preset),
    .req     (req),
    .advance (start),
    .gnt     (gnt)
  );

  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req != 2'b00) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command is captured only at the grant edge and held through ACCESS and IDLE.
  always_comb begin
    gnt_idx_d = gnt_idx_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start) begin
      gnt_idx_d = gnt[1];
      pwrite_d  = gnt[1] ? we[1] : we[0];
      paddr_d   = gnt[1] ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
      pwdata_d  = gnt[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end
    wait_d = '0;
    if ((state_q == ACCESS) && !finish) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_q    <= '0;
      gnt_idx_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      wait_q    <= wait_d;
      gnt_idx_q <= gnt_idx_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  // A reset landing on the completing cycle suppresses the done pulse.
  always_comb begin
    psel    = (state_q != IDLE);
    penable = (state_q == ACCESS);
    done    = 2'b00;
    rdata   = '0;
    err     = 1'b0;
    if (finish && !preset) begin
      done[gnt_idx_q] = 1'b1;
      if (pready) begin
        rdata = prdata;
        err   = pslverr;
      end else begin
        err = 1'b1;
      end
    end
  end

  assign pwrite = pwrite_q;
  assign paddr  = paddr_q;
  assign pwdata = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: a 32-word APB RAM slave with programmable wait states,
// and a transaction-level model predicting grant order, timing and read data.
module tb_apb_master_arb;
  import apb_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic            pclk = 1'b0;
  logic            preset;
  logic [1:0]      req, we, done;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]   rdata, pwdata, prdata;
  logic            err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .err(err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave: ready after wait_n ACCESS cycles unless stuck; error beyond word 31.
  logic [DW-1:0] smem [32];
  int            acc_cnt = 0;
  int            wait_n  = 0;
  bit            stuck   = 1'b0;
  logic          in_range;

  assign in_range = (paddr < AW'(32));
  assign pready   = psel && penable && !stuck && (acc_cnt >= wait_n);
  assign pslverr  = pready && !in_range;
  assign prdata   = (psel && !pwrite && in_range) ? smem[paddr[4:0]] : '0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && in_range) smem[paddr[4:0]] <= pwdata;
  end

  logic [DW-1:0] ref_mem [32];
  int            ptr_m = 0;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command per selected requester and follow both to completion.
  // Each transfer occupies IDLE + SETUP + (1 + waits) ACCESS cycles.
  task automatic xfer_pair(input bit v0, input bit v1, input apb_cmd_t c0, input apb_cmd_t c1,
                           input int w, input bit stk);
    apb_cmd_t      cs [2];
    apb_cmd_t      c;
    int            order [2];
    int            n, nw, last, s, t_act;
    logic [1:0]    exp_ps, exp_done;
    logic [DW-1:0] rd;
    logic          er;
    cs[0] = c0;
    cs[1] = c1;
    if (v0 && v1) begin
      order[0] = ptr_m; order[1] = 1 - ptr_m; n = 2;
    end else begin
      order[0] = v0 ? 0 : 1; order[1] = order[0]; n = 1;
    end
    ptr_m  = 1 - order[n-1];
    nw     = stk ? TMO : w;
    stuck  = stk;
    wait_n = w;
    req    = {v1, v0};
    we     = {c1.we, c0.we};
    addr   = {c1.addr, c0.addr};
    wdata  = {c1.wdata, c0.wdata};
    last   = n * (3 + nw);
    for (int k = 1; k <= last; k++) begin
      @(negedge pclk);
      exp_ps   = 2'b00;
      exp_done = 2'b00;
      t_act    = -1;
      for (int t = 0; t < n; t++) begin
        s = t * (3 + nw);
        if (k == s + 1) begin
          exp_ps = 2'b10; t_act = t;
        end else if (k >= s + 2 && k <= s + 2 + nw) begin
          exp_ps = 2'b11; t_act = t;
        end
      end
      chk_eq("psel_penable", {psel, penable}, exp_ps);
      if (t_act >= 0) begin
        c = cs[order[t_act]];
        if (exp_ps == 2'b10)
          chk_eq("setup_cmd", {pwrite, paddr, pwdata}, {c.we, c.addr, c.wdata});
        if (exp_ps == 2'b11 && k == t_act * (3 + nw) + 2 + nw) begin
          exp_done[order[t_act]] = 1'b1;
          if (stk || c.addr >= 32) begin
            er = 1'b1; rd = '0;
          end else begin
            er = 1'b0;
            rd = c.we ? '0 : ref_mem[c.addr[4:0]];
            if (c.we) ref_mem[c.addr[4:0]] = c.wdata;
          end
          chk_eq("err", err, er);
          chk_eq("rdata", rdata, rd);
          req[order[t_act]] = 1'b0;
        end
      end
      chk_eq("done", done, exp_done);
      if (exp_done == 2'b00) chk_eq("idle_outs", {rdata, err}, '0);
    end
  endtask

  function automatic apb_cmd_t mk(input logic w, input int a, input logic [31:0] d);
    apb_cmd_t c;
    c.we    = w;
    c.addr  = 32'(a);
    c.wdata = d;
    return c;
  endfunction

  initial begin
    apb_cmd_t   z, r0, r1;
    logic [1:0] vr;
    z = mk(1'b0, 0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      smem[i] = '0; ref_mem[i] = '0;
    end
    preset = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(negedge pclk);
    chk_eq("reset_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk_eq("reset_resp", {done, rdata, err}, '0);
    preset = 1'b0;

    // Simultaneous requests from reset, then readback of both
    xfer_pair(1'b1, 1'b1, mk(1'b1, 1, 32'h11), mk(1'b1, 2, 32'h22), 0, 1'b0);
    xfer_pair(1'b1, 1'b1, mk(1'b0, 1, 32'h0), mk(1'b0, 2, 32'h0), 0, 1'b0);
    // Write then read
    xfer_pair(1'b1, 1'b0, mk(1'b1, 5, 32'hA5A5_0001), z, 0, 1'b0);
    xfer_pair(1'b1, 1'b0, mk(1'b0, 5, 32'h0), z, 0, 1'b0);
    // Fairness: six back-to-back contended transfers
    for (int i = 0; i < 3; i++)
      xfer_pair(1'b1, 1'b1, mk(1'b1, 10 + i, 32'(i)), mk(1'b1, 20 + i, 32'(100 + i)), 0, 1'b0);
    // Slave error, wait states, timeout
    xfer_pair(1'b0, 1'b1, z, mk(1'b0, 40, 32'h0), 0, 1'b0);
    xfer_pair(1'b1, 1'b0, mk(1'b0, 5, 32'h0), z, 2, 1'b0);
    xfer_pair(1'b1, 1'b0, mk(1'b1, 6, 32'hDEAD_BEEF), z, 0, 1'b1);
    xfer_pair(1'b1, 1'b0, mk(1'b0, 6, 32'h0), z, 0, 1'b0);

    // Reset during a wait state
    stuck = 1'b1; req = 2'b01; we = 2'b00; addr = {32'd0, 32'd3};
    repeat (3) @(negedge pclk);
    chk_eq("pre_rst_ps", {psel, penable}, 2'b11);
    preset = 1'b1;
    @(negedge pclk);
    chk_eq("rst_ps", {psel, penable}, 2'b00);
    chk_eq("rst_done", done, 2'b00);
    chk_eq("rst_paddr", paddr, '0);
    preset = 1'b0; req = 2'b00; stuck = 1'b0; ptr_m = 0;
    xfer_pair(1'b1, 1'b1, mk(1'b1, 7, 32'h77), mk(1'b0, 6, 32'h0), 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      vr = 2'($urandom_range(1, 3));
      r0 = mk(1'($urandom_range(0, 1)), $urandom_range(0, 39), $urandom);
      r1 = mk(1'($urandom_range(0, 1)), $urandom_range(0, 39), $urandom);
      xfer_pair(vr[0], vr[1], r0, r1, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master that shares the single `apb_ram` slave port between internal requesters. Requesters use a simple req/done interface. The block performs round-robin arbitration, sequences the APB SETUP/ACCESS phases, and returns read data and error status to the granted requester. A wait-state timeout prevents a stuck `pready` from hanging the bus. It sits directly in front of `apb_ram`, driving its `psel/penable/pwrite/paddr/pwdata` and consuming `prdata/pready/pslverr`.

## Interface

Parameters:
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, max ACCESS wait cycles with `pready`=0 before abort; 0 disables the timeout

Ports:
- `pclk`  in  1  clock; all logic on rising edge
- `preset`  in  1  reset, synchronous, active-high
- `req`  in  2  per-requester transfer request, level
- `we`  in  2  per-requester direction, 1 = write
- `addr`  in  2*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
- `wdata`  in  2*DATA_W  per-requester write data, packed as `addr`
- `done`  out  2  one-cycle completion pulse to the granted requester
- `rdata`  out  DATA_W  read data, valid with `done`
- `err`  out  1  error flag, valid with `done`
- `psel`, `penable`, `pwrite`  out  1  APB controls
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB ready
- `pslverr`  in  1  APB slave error

## Operation

- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any `req` is high, pick the winner by round-robin, then go to SETUP.
  - On the same edge, register the winner's `we/addr/wdata` into `pwrite/paddr/pwdata` and record the grant index.
- **SETUP**: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- **ACCESS**: `psel`=1, `penable`=1.
  - `pready`=1: `done[gnt]`=1, `rdata`=`prdata`, `err`=`pslverr`. Next state IDLE.
  - `pready`=0: the wait counter increments.
  - Timeout: if `TIMEOUT`≠0 and `pready` is still 0 in the ACCESS cycle where the wait counter equals `TIMEOUT`, then `done[gnt]`=1, `err`=1, `rdata`=0. Next state IDLE.
- `done`, `rdata` and `err` are combinational from the ACCESS state and `pready`/the counter. `rdata`=0 and `err`=0 whenever `done`=0.
- `paddr`, `pwrite` and `pwdata` are held stable from SETUP through the end of ACCESS. They retain their last value in IDLE.
- **Round-robin**
  - A priority pointer starts at requester 0.
  - After a grant to i, the pointer moves to the other requester.
  - If only one requester is active, it wins regardless of the pointer.
- **Requester rules**
  - Hold `req` and the command stable until `done`.
  - Deassert `req` on the edge after `done`, or keep it high to request another transfer.
  - Commands are sampled only in IDLE.
- Reset clears the FSM to IDLE, the pointer to 0, and the wait counter to 0.

## Timing

- Reset values: `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `done`=0, `rdata`=0, `err`=0.
- Zero-wait transfer: `req` sampled in IDLE at cycle 0, SETUP at cycle 1, ACCESS with `done` at cycle 2. Minimum 3 cycles per transfer.
- There is always exactly one IDLE cycle between transfers, with `psel`=0.
- Each wait state adds one cycle.
- With `TIMEOUT`=N, the abort `done` falls in the (N+1)th ACCESS cycle.
- Both requests high in IDLE: the pointer decides the winner. The loser is served next if it still requests.
- `req` dropped before grant: it is ignored.
- `req` dropped while its transfer is in flight: the transfer still completes and `done` still pulses.
- `preset` mid-transfer: `psel` and `penable` go to 0 on that edge. No `done` is issued. The aborted transfer is lost.
- `pslverr` is sampled only when `pready`=1 in ACCESS.

## Structure

- Package `apb_ctrl_pkg` contains:
  - the state enum (`IDLE`, `SETUP`, `ACCESS`);
  - default `ADDR_W`/`DATA_W` localparams;
  - a requester command struct (we, addr, wdata).
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `advance`.
  - Output: one-hot `gnt[1:0]`.
  - Holds the pointer register.
- The top level holds the FSM, the command registers and the wait counter (width `$clog2(TIMEOUT+1)`, minimum 1).

## Test plan

- Write then read:
  - Requester 0 writes `0xA5A5_0001` to addr 5. Then requester 0 reads addr 5.
  - Required: `rdata`=`0xA5A5_0001`, `err`=0, `done[0]` pulses on the 3rd cycle of each transfer.
- Simultaneous requests:
  - Both requesters request from reset. Req0 writes addr 1 with `0x11`; req1 writes addr 2 with `0x22`.
  - Required: req0 is granted first, req1 second. Readback gives `0x11` and `0x22`. Exactly one IDLE cycle between the transfers.
- Fairness:
  - Both requesters hold `req` high for 6 transfers.
  - Required: grants alternate 0,1,0,1,0,1, with no starvation.
- Slave error:
  - Read addr 40 (out of range of the 32-word RAM).
  - Required: `done`, `err`=1 on the `pready` cycle.
- Wait states and timeout:
  - With `TIMEOUT`=4, force `pready`=0 for 2 cycles. Required: `done` in the 3rd ACCESS cycle, `err`=0.
  - Force `pready`=0 permanently. Required: `done` with `err`=1, `rdata`=0 in the 5th ACCESS cycle, then `psel`=0.
- Reset in ACCESS:
  - Assert `preset` during a wait state.
  - Required: `psel`=`penable`=0 on the next edge, no `done`, and the next request after release starts at SETUP normally.
